data_mem_unit: RTL

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/data_mem_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/data_mem_unit.sv
// Byte-addressable 32-bit data memory: word stores and loads complete in one cycle,
// sub-word stores take a read-merge-write pass through MERGE (ready low one cycle).
module data_mem_unit #(
    parameter int ADDR_W     = 10,
    parameter bit LITTLE_END = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {IDLE, MERGE} state_t;

    state_t            state;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] mrg_idx;
    logic [31:0]       mrg_mask;
    logic [31:0]       mrg_data;
    logic              accept;
    logic              misaligned;
    logic [4:0]        shamt;
    logic [31:0]       lane_mask;
    logic [31:0]       lane_data;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [31:0]       load_val;
    logic [31:0]       merged;
    logic              unused_addr;

    // Upper address bits are dropped so accesses wrap modulo the array depth.
    assign idx         = addr[ADDR_W+1:2];
    assign unused_addr = ^addr[31:ADDR_W+2];
    assign accept      = req & ready;

    always_comb begin
        misaligned = (size == 2'b11) ||
                     (size == SZ_HALF && addr[0]) ||
                     (size == SZ_WORD && addr[1:0] != 2'b00);

        shamt = 5'd0;
        if (size == SZ_BYTE)
            shamt = LITTLE_END ? {addr[1:0], 3'b000} : {~addr[1:0], 3'b000};
        else if (size == SZ_HALF)
            shamt = LITTLE_END ? {addr[1], 4'b0000} : {~addr[1], 4'b0000};

        if (size == SZ_BYTE) begin
            lane_mask = 32'h0000_00FF << shamt;
            lane_data = {24'd0, wdata[7:0]} << shamt;
        end else begin
            lane_mask = 32'h0000_FFFF << shamt;
            lane_data = {16'd0, wdata[15:0]} << shamt;
        end

        rd_word  = mem[idx];
        rd_shift = rd_word >> shamt;
        case (size)
            SZ_BYTE: load_val = {{24{sext & rd_shift[7]}}, rd_shift[7:0]};
            SZ_HALF: load_val = {{16{sext & rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = rd_word;
        endcase

        merged = (mem[mrg_idx] & ~mrg_mask) | mrg_data;
    end

    // The array shares this block so a reset edge also suppresses any pending write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ready    <= 1'b1;
            rvalid   <= 1'b0;
            err      <= 1'b0;
            rdata    <= 32'd0;
            mrg_idx  <= '0;
            mrg_mask <= 32'd0;
            mrg_data <= 32'd0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (misaligned) begin
                            err <= 1'b1;
                        end else if (!we) begin
                            rdata  <= load_val;
                            rvalid <= 1'b1;
                        end else if (size == SZ_WORD) begin
                            mem[idx] <= wdata;
                        end else begin
                            mrg_idx  <= idx;
                            mrg_mask <= lane_mask;
                            mrg_data <= lane_data;
                            state    <= MERGE;
                            ready    <= 1'b0;
                        end
                    end
                end
                MERGE: begin
                    mem[mrg_idx] <= merged;
                    state        <= IDLE;
                    ready        <= 1'b1;
                end
            endcase
        end
    end
endmodule
